// File: rtl/skip_fifo_pkg.sv
// Shared types and helpers for the variable-stride FIFO.
// Holds the read-stride clamp and the occupancy-to-flag mapping.
package skip_fifo_pkg;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } flags_t;

  // Entries consumed by one accepted read: a zero stride still consumes one entry,
  // and a read never takes more than is currently stored.
  function automatic int clamp_skip(input int skip, input int used);
    int s;
    s = (skip < 1) ? 1 : skip;
    return (s > used) ? used : s;
  endfunction

  function automatic flags_t calc_flags(input int used, input int ae_lvl,
                                        input int af_lvl, input int depth);
    flags_t f;
    f.empty        = (used == 0);
    f.full         = (used == depth);
    f.almost_empty = (used <= ae_lvl);
    f.almost_full  = (used >= af_lvl);
    return f;
  endfunction

endpackage

// File: rtl/skip_fifo_if.sv
// Producer/consumer bus of the skip FIFO.
// The slave side is the FIFO itself.
interface skip_fifo_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
);
  logic              wr_i;
  logic [DWIDTH-1:0] wrdata_i;
  logic              rd_i;
  logic [AWIDTH:0]   skip_i;
  logic [DWIDTH-1:0] rddata_o;
  logic [AWIDTH:0]   usedw_o;
  logic              empty_o;
  logic              full_o;
  logic              almost_empty_o;
  logic              almost_full_o;
  logic              ovf_o;
  logic              udf_o;

  modport master (
    output wr_i, wrdata_i, rd_i, skip_i,
    input  rddata_o, usedw_o, empty_o, full_o, almost_empty_o, almost_full_o, ovf_o, udf_o
  );

  modport slave (
    input  wr_i, wrdata_i, rd_i, skip_i,
    output rddata_o, usedw_o, empty_o, full_o, almost_empty_o, almost_full_o, ovf_o, udf_o
  );
endinterface

// File: rtl/skip_fifo_ram.sv
// Simple dual-port storage for the skip FIFO.
// Read port is combinational (show-ahead) or registered with a read enable.
module skip_fifo_ram #(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 4,
  parameter bit SHOWAHEAD = 1'b1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  // NOTE: storage has no reset on purpose; pointers and count define validity,
  // and a reset-free array maps onto RAM primitives instead of flops.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  if (SHOWAHEAD) begin : g_showahead
    assign rdata_o = mem[raddr_i];
  end else begin : g_registered
    logic [DWIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (re_i) rdata_d = mem[raddr_i];
    end

    always_ff @(posedge clk_i) begin
      if (srst_i) rdata_q <= '0;
      else        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;
  end

endmodule

// File: rtl/skip_fifo.sv
// Single-clock FIFO whose reads consume 1..DEPTH entries at once.
// Occupancy is tracked by a counter so flags stay exact for any stride.
module skip_fifo
  import skip_fifo_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 4,
  parameter bit SHOWAHEAD = 1'b1,
  parameter int AE_LVL    = 1,
  parameter int AF_LVL    = 14
) (
  input  logic       clk_i,
  input  logic       srst_i,
  skip_fifo_if.slave bus
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam int UW    = AWIDTH + 1;

  logic [AWIDTH-1:0] wrptr_q, wrptr_d, rdptr_q, rdptr_d;
  logic [UW-1:0]     usedw_q, usedw_d, n_rd;
  flags_t            flags_q, flags_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              rd_acc, wr_acc;
  logic [DWIDTH-1:0] rdata;

  // NOTE: every signal here is assigned on every path, so no latch can be inferred.
  always_comb begin
    rd_acc  = bus.rd_i & ~flags_q.empty;
    // Clamp against pre-write occupancy: a same-cycle write is never consumed.
    n_rd    = rd_acc ? UW'(clamp_skip(32'(bus.skip_i), 32'(usedw_q))) : '0;
    wr_acc  = bus.wr_i & (~flags_q.full | rd_acc);
    wrptr_d = wrptr_q + AWIDTH'(wr_acc);
    rdptr_d = rdptr_q + n_rd[AWIDTH-1:0];
    usedw_d = usedw_q + UW'(wr_acc) - n_rd;
    flags_d = calc_flags(32'(usedw_d), AE_LVL, AF_LVL, DEPTH);
    ovf_d   = ovf_q | (bus.wr_i & ~wr_acc);
    udf_d   = udf_q | (bus.rd_i & flags_q.empty);
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wrptr_q <= '0;
      rdptr_q <= '0;
      usedw_q <= '0;
      flags_q <= calc_flags(0, AE_LVL, AF_LVL, DEPTH);
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      usedw_q <= usedw_d;
      flags_q <= flags_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  skip_fifo_ram #(
    .DWIDTH   (DWIDTH),
    .AWIDTH   (AWIDTH),
    .SHOWAHEAD(SHOWAHEAD)
  ) u_ram (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .we_i   (wr_acc),
    .waddr_i(wrptr_q),
    .wdata_i(bus.wrdata_i),
    .re_i   (rd_acc),
    .raddr_i(rdptr_q),
    .rdata_o(rdata)
  );

  assign bus.rddata_o       = rdata;
  assign bus.usedw_o        = usedw_q;
  assign bus.empty_o        = flags_q.empty;
  assign bus.full_o         = flags_q.full;
  assign bus.almost_empty_o = flags_q.almost_empty;
  assign bus.almost_full_o  = flags_q.almost_full;
  assign bus.ovf_o          = ovf_q;
  assign bus.udf_o          = udf_q;

endmodule

// File: tb/tb_skip_fifo.sv
// Directed bench for skip_fifo at DEPTH 4: a show-ahead instance and a
// registered-read instance, each tracked by a reference queue.
module tb_skip_fifo;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic srst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  skip_fifo_if #(.DWIDTH(DW), .AWIDTH(AW)) sa_if ();
  skip_fifo_if #(.DWIDTH(DW), .AWIDTH(AW)) rg_if ();

  skip_fifo #(.DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD(1'b1), .AE_LVL(1), .AF_LVL(3))
    dut_sa (.clk_i(clk), .srst_i(srst), .bus(sa_if));
  skip_fifo #(.DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD(1'b0), .AE_LVL(1), .AF_LVL(3))
    dut_rg (.clk_i(clk), .srst_i(srst), .bus(rg_if));

  logic [DW-1:0] ref_q[$];
  logic [DW-1:0] rg_q[$];
  logic [DW-1:0] rg_exp[$];
  logic          m_ovf, m_udf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle on the show-ahead DUT; the reference queue follows the same rules.
  task automatic op(input logic wr, input logic [DW-1:0] d, input logic rd, input logic [AW:0] skip);
    int  n;
    bit  racc, wacc;
    @(negedge clk);
    sa_if.wr_i = wr; sa_if.wrdata_i = d; sa_if.rd_i = rd; sa_if.skip_i = skip;
    racc = rd && ref_q.size() != 0;
    n    = racc ? ((skip == 0) ? 1 : int'(skip)) : 0;
    if (n > ref_q.size()) n = ref_q.size();
    wacc = wr && (ref_q.size() < DEPTH || racc);
    if (wr && !wacc) m_ovf = 1'b1;
    if (rd && ref_q.size() == 0) m_udf = 1'b1;
    for (int i = 0; i < n; i++) void'(ref_q.pop_front());
    if (wacc) ref_q.push_back(d);
    @(posedge clk); #1;
    sa_if.wr_i = 1'b0; sa_if.rd_i = 1'b0;
  endtask

  // Same for the registered-read DUT; expected read word is queued on acceptance.
  task automatic rop(input logic wr, input logic [DW-1:0] d, input logic rd, input logic [AW:0] skip);
    int n;
    @(negedge clk);
    rg_if.wr_i = wr; rg_if.wrdata_i = d; rg_if.rd_i = rd; rg_if.skip_i = skip;
    if (rd && rg_q.size() != 0) begin
      n = (skip == 0) ? 1 : int'(skip);
      if (n > rg_q.size()) n = rg_q.size();
      rg_exp.push_back(rg_q[0]);
      for (int i = 0; i < n; i++) void'(rg_q.pop_front());
    end
    if (wr && rg_q.size() < DEPTH) rg_q.push_back(d);
    @(posedge clk); #1;
    rg_if.wr_i = 1'b0; rg_if.rd_i = 1'b0;
  endtask

  task automatic do_reset(input logic rd, input logic wr);
    @(negedge clk);
    srst = 1'b1; sa_if.rd_i = rd; sa_if.wr_i = wr; sa_if.wrdata_i = 8'hEE; sa_if.skip_i = 3'd1;
    @(posedge clk); #1;
    srst = 1'b0; sa_if.rd_i = 1'b0; sa_if.wr_i = 1'b0;
    ref_q.delete(); rg_q.delete(); rg_exp.delete();
    m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic check_state(input string tag);
    int sz;
    sz = ref_q.size();
    check({tag, ".usedw"}, 32'(sa_if.usedw_o),      sz);
    check({tag, ".empty"}, 32'(sa_if.empty_o),      32'(sz == 0));
    check({tag, ".full"},  32'(sa_if.full_o),       32'(sz == DEPTH));
    check({tag, ".ae"},    32'(sa_if.almost_empty_o), 32'(sz <= 1));
    check({tag, ".af"},    32'(sa_if.almost_full_o),  32'(sz >= 3));
    check({tag, ".ovf"},   32'(sa_if.ovf_o),        32'(m_ovf));
    check({tag, ".udf"},   32'(sa_if.udf_o),        32'(m_udf));
    if (sz != 0) check({tag, ".head"}, 32'(sa_if.rddata_o), 32'(ref_q[0]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b1;
    sa_if.wr_i = 1'b0; sa_if.rd_i = 1'b0; sa_if.wrdata_i = '0; sa_if.skip_i = '0;
    rg_if.wr_i = 1'b0; rg_if.rd_i = 1'b0; rg_if.wrdata_i = '0; rg_if.skip_i = '0;
    m_ovf = 1'b0; m_udf = 1'b0;
    repeat (2) @(posedge clk);
    #1 srst = 1'b0;

    // Reset state
    check_state("rst");
    check("rst.ae_const", 32'(sa_if.almost_empty_o), 32'd1);
    check("rst.rg_rddata", 32'(rg_if.rddata_o), 32'd0);

    // 1: overfill
    do_reset(1'b0, 1'b0);
    op(1, 8'h11, 0, 0); op(1, 8'h22, 0, 0); op(1, 8'h33, 0, 0); op(1, 8'h44, 0, 0);
    op(1, 8'h55, 0, 0);
    check_state("s1");
    check("s1.full", 32'(sa_if.full_o), 32'd1);
    check("s1.ovf", 32'(sa_if.ovf_o), 32'd1);
    check("s1.head", 32'(sa_if.rddata_o), 32'h11);

    // 2: skip reads and clamp
    do_reset(1'b0, 1'b0);
    op(1, 8'h10, 0, 0); op(1, 8'h20, 0, 0); op(1, 8'h30, 0, 0); op(1, 8'h40, 0, 0);
    op(0, 8'h00, 1, 3'd2);
    check_state("s2a");
    check("s2a.head", 32'(sa_if.rddata_o), 32'h30);
    op(0, 8'h00, 1, 3'd5);
    check_state("s2b");
    check("s2b.empty", 32'(sa_if.empty_o), 32'd1);
    check("s2b.udf", 32'(sa_if.udf_o), 32'd0);

    // 3: simultaneous read/write when full, then when empty
    do_reset(1'b0, 1'b0);
    op(1, 8'hA1, 0, 0); op(1, 8'hA2, 0, 0); op(1, 8'hA3, 0, 0); op(1, 8'hA4, 0, 0);
    op(1, 8'h99, 1, 3'd1);
    check_state("s3a");
    check("s3a.usedw", 32'(sa_if.usedw_o), 32'd4);
    check("s3a.ovf", 32'(sa_if.ovf_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      op(0, 8'h00, 1, 3'd1);
      check_state("s3r");
    end
    check("s3.last", 32'(sa_if.rddata_o), 32'h99);
    op(0, 8'h00, 1, 3'd0);
    check_state("s3e");
    op(1, 8'h77, 1, 3'd1);
    check_state("s3b");
    check("s3b.udf", 32'(sa_if.udf_o), 32'd1);
    check("s3b.head", 32'(sa_if.rddata_o), 32'h77);

    // 4: streaming pairs, then stride-3 reads across the wrap
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      op(1, 8'(i), 0, 0);
      check_state("s4w");
      op(0, 8'h00, 1, 3'd1);
      check_state("s4r");
    end
    for (int i = 0; i < 4; i++) op(1, 8'hB0 + 8'(i), 0, 0);
    op(0, 8'h00, 1, 3'd3);
    check_state("s4s1");
    for (int i = 0; i < 3; i++) op(1, 8'hC0 + 8'(i), 0, 0);
    op(1, 8'hD0, 1, 3'd3);
    check_state("s4s2");
    op(0, 8'h00, 1, 3'd3);
    check_state("s4s3");

    // 5: reset overrides read/write
    do_reset(1'b0, 1'b0);
    op(1, 8'h01, 0, 0); op(1, 8'h02, 0, 0); op(1, 8'h03, 0, 0);
    op(1, 8'h04, 0, 0); op(1, 8'h05, 0, 0);
    do_reset(1'b1, 1'b1);
    check_state("s5");
    check("s5.ovf", 32'(sa_if.ovf_o), 32'd0);

    // 6: almost-empty / almost-full thresholds
    for (int k = 0; k <= DEPTH; k++) begin
      check("s6.ae", 32'(sa_if.almost_empty_o), 32'(k <= 1));
      check("s6.af", 32'(sa_if.almost_full_o), 32'(k >= 3));
      if (k < DEPTH) op(1, 8'h60 + 8'(k), 0, 0);
    end

    // 6b: registered read data
    for (int i = 0; i < 4; i++) rop(1, 8'h50 + 8'(i), 0, 0);
    check("s6b.hold0", 32'(rg_if.rddata_o), 32'd0);
    rop(0, 8'h00, 1, 3'd2);
    check("s6b.rd1", 32'(rg_if.rddata_o), 32'(rg_exp.pop_front()));
    check("s6b.usedw", 32'(rg_if.usedw_o), 32'd2);
    rop(0, 8'h00, 0, 0);
    check("s6b.hold", 32'(rg_if.rddata_o), 32'h50);
    rop(0, 8'h00, 1, 3'd1);
    check("s6b.rd2", 32'(rg_if.rddata_o), 32'(rg_exp.pop_front()));
    check("s6b.rd2c", 32'(rg_if.rddata_o), 32'h52);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
